mpls_ingress_dwrr_scheduler: RTL and testbench

- Deficit-weighted round-robin packet scheduler for the MPLS ingress converged bus.
- Sits between the per-physical-port adapted/tuser-tagged AXIS streams and the converged-bus mux. It decides which port owns the mux and holds that grant for whole packets.
- Replaces plain round-robin, so per-port byte share is set by a runtime-configurable quantum regardless of packet size.

---
 rtl/mpls_ingress_dwrr_scheduler.sv | 275 +++++++++++++++++++++++++++
 tb/tb_mpls_ingress_dwrr_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpls_ingress_dwrr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mpls_ingress_dwrr_scheduler
// Purpose  : Deficit-weighted round-robin packet scheduler for the MPLS
//            ingress converged bus. Chooses which physical port owns the
//            converged-bus mux and holds that grant for whole packets. Each
//            port's byte share is set by a runtime-programmable quantum.
// Ports    : clk_i / reset_i    core clock, asynchronous active-high reset
//            req_i              per-port head-beat valid
//            beat_accept_i      handshake of the granted port's beat
//            beat_last_i        tlast of the accepted beat
//            beat_bytes_i       byte count of the accepted beat
//            quantum_wr_*_i     quantum programming (0 disables a port)
//            grant_o            one-hot mux select
//            grant_index_o      encoded grant
//            grant_valid_o      grant is live
//            deficit_neg_o      per-port deficit sign
// Options  : define MPLS_ING_SCHED_STATS_EN to add per-port packet/byte
//            counters with a combinational read port (stats_*).
// Revision : 1.0  initial release
// ============================================================================
module mpls_ingress_dwrr_scheduler #(
  parameter int NUM_PORTS       = 4,
  parameter int PORT_W          = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  parameter int BEAT_BYTES_W    = 7,
  parameter int QUANTUM_W       = 16,
  parameter int DEFAULT_QUANTUM = 9600,
  parameter int DEFICIT_W       = QUANTUM_W + 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NUM_PORTS-1:0]    req_i,
  input  logic                    beat_accept_i,
  input  logic                    beat_last_i,
  input  logic [BEAT_BYTES_W-1:0] beat_bytes_i,
  input  logic                    quantum_wr_en_i,
  input  logic [PORT_W-1:0]       quantum_wr_port_i,
  input  logic [QUANTUM_W-1:0]    quantum_wr_data_i,
`ifdef MPLS_ING_SCHED_STATS_EN
  input  logic [PORT_W-1:0]       stats_rd_port_i,
  input  logic                    stats_clear_i,
  output logic [31:0]             stats_pkts_o,
  output logic [39:0]             stats_bytes_o,
`endif
  output logic [NUM_PORTS-1:0]    grant_o,
  output logic [PORT_W-1:0]       grant_index_o,
  output logic                    grant_valid_o,
  output logic [NUM_PORTS-1:0]    deficit_neg_o
);

  // Arithmetic is done one bit wider than the deficit so overflow can be
  // detected and clamped.
  localparam int SUM_W = DEFICIT_W + 1;
  localparam logic signed [SUM_W-1:0] DEF_MAX = $signed({2'b00, {(DEFICIT_W-1){1'b1}}});
  localparam logic signed [SUM_W-1:0] DEF_MIN = $signed({2'b11, {(DEFICIT_W-1){1'b0}}});
  localparam logic [PORT_W:0]   NUM_PORTS_EXT = (PORT_W+1)'(NUM_PORTS);
  localparam logic [PORT_W-1:0] LAST_PORT     = PORT_W'(NUM_PORTS-1);

  typedef enum logic [0:0] {
    ST_SELECT = 1'b0,
    ST_GRANT  = 1'b1
  } state_t;

  state_t                      state_q;
  logic [PORT_W-1:0]           ptr_q;
  logic [NUM_PORTS-1:0]        grant_q;
  logic [PORT_W-1:0]           grant_index_q;
  logic                        grant_valid_q;
  logic                        in_pkt_q;
  logic signed [DEFICIT_W-1:0] deficit_q [NUM_PORTS];
  logic signed [DEFICIT_W-1:0] deficit_d [NUM_PORTS];
  logic [QUANTUM_W-1:0]        quantum_q [NUM_PORTS];
  logic [NUM_PORTS-1:0]        deficit_neg_q;
  logic [NUM_PORTS-1:0]        deficit_neg_d;

  function automatic logic [PORT_W-1:0] next_port(input logic [PORT_W-1:0] p);
    return (p == LAST_PORT) ? '0 : p + PORT_W'(1);
  endfunction

  // --------------------------------------------------------------------------
  // Round-robin scan from the pointer: first eligible port wins; every port
  // visited before it is marked as passed over.
  // --------------------------------------------------------------------------
  logic                 scan_found;
  logic [PORT_W-1:0]    scan_sel;
  logic [NUM_PORTS-1:0] scan_pass;
  logic [PORT_W:0]      scan_idx;

  always_comb begin
    scan_found = 1'b0;
    scan_sel   = '0;
    scan_pass  = '0;
    scan_idx   = '0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      scan_idx = {1'b0, ptr_q} + (PORT_W+1)'(off);
      if (scan_idx >= NUM_PORTS_EXT) begin
        scan_idx = scan_idx - NUM_PORTS_EXT;
      end
      if (!scan_found) begin
        if (req_i[scan_idx[PORT_W-1:0]] && (quantum_q[scan_idx[PORT_W-1:0]] != '0)) begin
          scan_found = 1'b1;
          scan_sel   = scan_idx[PORT_W-1:0];
        end else begin
          scan_pass[scan_idx[PORT_W-1:0]] = 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Saturating deficit arithmetic: credit on selection, debit on each beat.
  // --------------------------------------------------------------------------
  logic signed [SUM_W-1:0]     add_sum;
  logic signed [SUM_W-1:0]     sub_diff;
  logic signed [DEFICIT_W-1:0] add_sat;
  logic signed [DEFICIT_W-1:0] sub_sat;
  logic                        add_pos;
  logic                        sub_pos;

  always_comb begin
    add_sum  = $signed({deficit_q[scan_sel][DEFICIT_W-1], deficit_q[scan_sel]})
             + $signed({{(SUM_W-QUANTUM_W){1'b0}}, quantum_q[scan_sel]});
    sub_diff = $signed({deficit_q[grant_index_q][DEFICIT_W-1], deficit_q[grant_index_q]})
             - $signed({{(SUM_W-BEAT_BYTES_W){1'b0}}, beat_bytes_i});
    add_sat  = (add_sum > DEF_MAX)  ? DEF_MAX[DEFICIT_W-1:0] : add_sum[DEFICIT_W-1:0];
    sub_sat  = (sub_diff < DEF_MIN) ? DEF_MIN[DEFICIT_W-1:0] : sub_diff[DEFICIT_W-1:0];
    add_pos  = !add_sat[DEFICIT_W-1] && (add_sat != '0);
    sub_pos  = !sub_sat[DEFICIT_W-1] && (sub_sat != '0);
  end

  // --------------------------------------------------------------------------
  // Deficit next-state and scheduling decisions.
  // --------------------------------------------------------------------------
  logic start_grant;
  logic skip_port;
  logic release_grant;

  always_comb begin
    deficit_d     = deficit_q;
    start_grant   = 1'b0;
    skip_port     = 1'b0;
    release_grant = 1'b0;
    case (state_q)
      ST_SELECT: begin
        // Idle or disabled ports lose any carried credit.
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (scan_pass[i]) begin
            deficit_d[i] = '0;
          end
        end
        if (scan_found) begin
          deficit_d[scan_sel] = add_sat;
          if (add_pos) begin
            start_grant = 1'b1;
          end else begin
            skip_port = 1'b1;
          end
        end
      end
      ST_GRANT: begin
        if (beat_accept_i) begin
          deficit_d[grant_index_q] = sub_sat;
          // A port disabled mid-packet does not get a follow-on packet.
          if (beat_last_i && !(sub_pos && (quantum_q[grant_index_q] != '0))) begin
            release_grant = 1'b1;
          end
        end else if (!in_pkt_q && !req_i[grant_index_q]) begin
          // Between packets with nothing queued: give up the grant and the
          // leftover credit (deficit only survives while backlogged).
          release_grant            = 1'b1;
          deficit_d[grant_index_q] = '0;
        end
      end
      default: ;
    endcase
    for (int i = 0; i < NUM_PORTS; i++) begin
      deficit_neg_d[i] = deficit_d[i][DEFICIT_W-1];
    end
  end

  // --------------------------------------------------------------------------
  // Scheduler FSM with registered grant outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= ST_SELECT;
      ptr_q         <= '0;
      grant_q       <= '0;
      grant_index_q <= '0;
      grant_valid_q <= 1'b0;
      in_pkt_q      <= 1'b0;
      deficit_neg_q <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        deficit_q[i] <= '0;
      end
    end else begin
      deficit_q     <= deficit_d;
      deficit_neg_q <= deficit_neg_d;
      case (state_q)
        ST_SELECT: begin
          if (start_grant) begin
            state_q       <= ST_GRANT;
            grant_q       <= NUM_PORTS'(1) << scan_sel;
            grant_index_q <= scan_sel;
            grant_valid_q <= 1'b1;
            in_pkt_q      <= 1'b0;
          end else if (skip_port) begin
            ptr_q <= next_port(scan_sel);
          end
        end
        ST_GRANT: begin
          if (release_grant) begin
            state_q       <= ST_SELECT;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            in_pkt_q      <= 1'b0;
            ptr_q         <= next_port(grant_index_q);
          end else if (beat_accept_i) begin
            in_pkt_q <= !beat_last_i;
          end
        end
        default: state_q <= ST_SELECT;
      endcase
    end
  end

  // Quantum table; a write only affects the next credit addition.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        quantum_q[i] <= QUANTUM_W'(DEFAULT_QUANTUM);
      end
    end else if (quantum_wr_en_i && ({1'b0, quantum_wr_port_i} < NUM_PORTS_EXT)) begin
      quantum_q[quantum_wr_port_i] <= quantum_wr_data_i;
    end
  end

  assign grant_o       = grant_q;
  assign grant_index_o = grant_index_q;
  assign grant_valid_o = grant_valid_q;
  assign deficit_neg_o = deficit_neg_q;

`ifdef MPLS_ING_SCHED_STATS_EN
  // Per-port granted packet and byte counters; clear wins over a same-cycle
  // accept, and counters wrap.
  logic [31:0] stats_pkts_q  [NUM_PORTS];
  logic [39:0] stats_bytes_q [NUM_PORTS];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        stats_pkts_q[i]  <= '0;
        stats_bytes_q[i] <= '0;
      end
    end else if (stats_clear_i) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        stats_pkts_q[i]  <= '0;
        stats_bytes_q[i] <= '0;
      end
    end else if (grant_valid_q && beat_accept_i) begin
      stats_bytes_q[grant_index_q] <= stats_bytes_q[grant_index_q] + 40'(beat_bytes_i);
      if (beat_last_i) begin
        stats_pkts_q[grant_index_q] <= stats_pkts_q[grant_index_q] + 32'd1;
      end
    end
  end

  assign stats_pkts_o  = stats_pkts_q[stats_rd_port_i];
  assign stats_bytes_o = stats_bytes_q[stats_rd_port_i];
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_mpls_ingress_dwrr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mpls_ingress_dwrr_scheduler
// Purpose  : Self-checking bench for mpls_ingress_dwrr_scheduler: a vector
//            table, directed multi-cycle sequences (back-to-back packets,
//            oversize packet with small quantum, asynchronous reset) and a
//            randomized run against a packet-level DWRR reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mpls_ingress_dwrr_scheduler;

  localparam int NP   = 4;
  localparam int NPKT = 200;
  localparam int MAXL = 320;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req;
  logic       acc;
  logic       lst;
  logic [6:0] nbytes;
  logic       qwe;
  logic [1:0] qport;
  logic [15:0] qdata;
  logic [3:0] grant;
  logic [1:0] gidx;
  logic       gv;
  logic [3:0] neg;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mpls_ingress_dwrr_scheduler #(
    .NUM_PORTS(4), .PORT_W(2), .BEAT_BYTES_W(7), .QUANTUM_W(16),
    .DEFAULT_QUANTUM(9600), .DEFICIT_W(18)
  ) dut (
    .clk_i            (clk),
    .reset_i          (rst),
    .req_i            (req),
    .beat_accept_i    (acc),
    .beat_last_i      (lst),
    .beat_bytes_i     (nbytes),
    .quantum_wr_en_i  (qwe),
    .quantum_wr_port_i(qport),
    .quantum_wr_data_i(qdata),
    .grant_o          (grant),
    .grant_index_o    (gidx),
    .grant_valid_o    (gv),
    .deficit_neg_o    (neg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    req = '0; acc = 0; lst = 0; nbytes = '0; qwe = 0; qport = '0; qdata = '0;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic        acc;
    logic        lst;
    logic [6:0]  nb;
    logic        qwe;
    logic [1:0]  qport;
    logic [15:0] qdata;
    logic        exp_gv;
    logic [1:0]  exp_idx;
    logic [3:0]  exp_neg;
  } vec_t;

  function automatic vec_t mk(logic [3:0] r, logic a, logic l, logic [6:0] b,
                              logic w, logic [1:0] wp, logic [15:0] wd,
                              logic eg, logic [1:0] ei, logic [3:0] en);
    vec_t v;
    v.req = r; v.acc = a; v.lst = l; v.nb = b; v.qwe = w; v.qport = wp; v.qdata = wd;
    v.exp_gv = eg; v.exp_idx = ei; v.exp_neg = en;
    return v;
  endfunction

  vec_t vecs [20];

  // Random-run state
  int q [NP];
  int lens [NP][MAXL];
  int mpi [NP];
  int dpi [NP];
  int dm [NP];
  int expq [$];

  initial begin
    int ptr, npk, cyc, rem, cur, drops, visits;
    logic inpkt;
    logic [3:0] exp_grant;

    // ---------------- Vector table (applied in order from reset) ----------
    vecs[0]  = mk(4'b1000, 0, 0, 7'd0,  0, 2'd0, 16'd0,   1, 2'd3, 4'b0000); // only port 3 requests
    vecs[1]  = mk(4'b1000, 1, 0, 7'd64, 0, 2'd0, 16'd0,   1, 2'd3, 4'b0000);
    vecs[2]  = mk(4'b1000, 1, 1, 7'd64, 0, 2'd0, 16'd0,   1, 2'd3, 4'b0000); // keep: credit left
    vecs[3]  = mk(4'b0000, 0, 0, 7'd0,  0, 2'd0, 16'd0,   0, 2'd0, 4'b0000); // req gone: release
    vecs[4]  = mk(4'b0000, 0, 0, 7'd0,  1, 2'd1, 16'd64,  0, 2'd0, 4'b0000); // quantum1 = 64
    vecs[5]  = mk(4'b0010, 0, 0, 7'd0,  0, 2'd0, 16'd0,   1, 2'd1, 4'b0000); // deficit1 = 64
    vecs[6]  = mk(4'b0010, 1, 0, 7'd64, 0, 2'd0, 16'd0,   1, 2'd1, 4'b0000); // 0
    vecs[7]  = mk(4'b0010, 1, 0, 7'd64, 0, 2'd0, 16'd0,   1, 2'd1, 4'b0010); // -64
    vecs[8]  = mk(4'b0010, 1, 1, 7'd10, 0, 2'd0, 16'd0,   0, 2'd0, 4'b0010); // -74, release
    vecs[9]  = mk(4'b0010, 0, 0, 7'd0,  0, 2'd0, 16'd0,   0, 2'd0, 4'b0010); // -10, skipped
    vecs[10] = mk(4'b0010, 0, 0, 7'd0,  0, 2'd0, 16'd0,   1, 2'd1, 4'b0000); // 54, granted
    vecs[11] = mk(4'b0010, 1, 1, 7'd64, 0, 2'd0, 16'd0,   0, 2'd0, 4'b0010); // -10, release
    vecs[12] = mk(4'b0000, 1, 1, 7'd64, 0, 2'd0, 16'd0,   0, 2'd0, 4'b0000); // idle clears; accept ignored
    vecs[13] = mk(4'b0001, 0, 0, 7'd0,  1, 2'd0, 16'd0,   1, 2'd0, 4'b0000); // old quantum used
    vecs[14] = mk(4'b0001, 1, 1, 7'd64, 0, 2'd0, 16'd0,   0, 2'd0, 4'b0000); // disabled: no follow-on
    vecs[15] = mk(4'b0001, 0, 0, 7'd0,  0, 2'd0, 16'd0,   0, 2'd0, 4'b0000); // skipped
    vecs[16] = mk(4'b0001, 0, 0, 7'd0,  1, 2'd0, 16'd500, 0, 2'd0, 4'b0000); // restore 500
    vecs[17] = mk(4'b0001, 0, 0, 7'd0,  0, 2'd0, 16'd0,   1, 2'd0, 4'b0000); // granted again
    vecs[18] = mk(4'b0001, 1, 1, 7'd64, 0, 2'd0, 16'd0,   1, 2'd0, 4'b0000);
    vecs[19] = mk(4'b0000, 0, 0, 7'd0,  0, 2'd0, 16'd0,   0, 2'd0, 4'b0000);

    idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_gv",    32'(gv),    32'd0);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_idx",   32'(gidx),  32'd0);
    check("reset_neg",   32'(neg),   32'd0);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req = vecs[i].req; acc = vecs[i].acc; lst = vecs[i].lst; nbytes = vecs[i].nb;
      qwe = vecs[i].qwe; qport = vecs[i].qport; qdata = vecs[i].qdata;
      @(posedge clk); #1;
      exp_grant = vecs[i].exp_gv ? (4'b0001 << vecs[i].exp_idx) : 4'b0000;
      check($sformatf("vec%0d_gv", i),    32'(gv),    32'(vecs[i].exp_gv));
      check($sformatf("vec%0d_grant", i), 32'(grant), 32'(exp_grant));
      check($sformatf("vec%0d_neg", i),   32'(neg),   32'(vecs[i].exp_neg));
      if (vecs[i].exp_gv) check($sformatf("vec%0d_idx", i), 32'(gidx), 32'(vecs[i].exp_idx));
    end

    // ---------------- Asynchronous reset mid-packet -----------------------
    @(negedge clk); idle(); qwe = 1; qport = 2'd2; qdata = 16'd64;
    @(negedge clk); idle(); req = 4'b0100;
    @(posedge clk); #1;
    check("rstseq_grant2", 32'(gidx), 32'd2);
    @(negedge clk); acc = 1; lst = 0; nbytes = 7'd64;
    @(negedge clk);
    @(posedge clk); #1;
    check("rstseq_neg_before", 32'(neg), 32'b0100);
    #1 rst = 1'b1;
    #1;
    check("rstseq_gv_async",    32'(gv),    32'd0);
    check("rstseq_grant_async", 32'(grant), 32'd0);
    check("rstseq_neg_async",   32'(neg),   32'd0);
    @(negedge clk); rst = 1'b0; idle();

    // ---------------- Back-to-back 64 B packets, default quanta -----------
    @(negedge clk); req = 4'b0110;
    @(posedge clk); #1;
    check("b2b_first_gv",  32'(gv),   32'd1);
    check("b2b_first_idx", 32'(gidx), 32'd1);
    drops = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk); acc = 1; lst = 1; nbytes = 7'd64;
      @(posedge clk); #1;
      if (i < 149) begin
        if (gv !== 1'b1 || gidx !== 2'd1) drops++;
      end else begin
        check("b2b_release_after_150", 32'(gv), 32'd0);
      end
    end
    check("b2b_no_gap_drops", 32'(drops), 32'd0);
    @(negedge clk); acc = 0; lst = 0; nbytes = '0;
    @(posedge clk); #1;
    check("b2b_next_gv",  32'(gv),   32'd1);
    check("b2b_next_idx", 32'(gidx), 32'd2);

    // ---------------- 9600 B packet with 64 B quantum ---------------------
    @(negedge clk); rst = 1'b1; idle();
    @(negedge clk); rst = 1'b0; qwe = 1; qport = 2'd2; qdata = 16'd64;
    @(negedge clk); idle(); req = 4'b0100;
    @(posedge clk); #1;
    check("big_grant_idx", 32'(gidx), 32'd2);
    for (int b = 0; b < 150; b++) begin
      @(negedge clk); acc = 1; lst = (b == 149); nbytes = 7'd64;
      @(posedge clk); #1;
      if (b < 149 && gv !== 1'b1) check($sformatf("big_held_beat%0d", b), 32'(gv), 32'd1);
    end
    check("big_release_gv", 32'(gv),  32'd0);
    check("big_neg",        32'(neg), 32'b0100);
    @(negedge clk); acc = 0; lst = 0; nbytes = '0;
    visits = 0;
    while (visits < 400) begin
      @(posedge clk); #1;
      visits++;
      if (gv) break;
    end
    check("big_regrant_visits", 32'(visits), 32'd150);
    check("big_regrant_idx",    32'(gidx),   32'd2);

    // ---------------- Randomized run vs packet-level DWRR model -----------
    @(negedge clk); rst = 1'b1; idle();
    @(negedge clk); rst = 1'b0;
    for (int p = 0; p < NP; p++) begin
      q[p] = (p == 0 || $urandom_range(4, 0) != 0) ? int'($urandom_range(1500, 64)) : 0;
      mpi[p] = 0; dpi[p] = 0; dm[p] = 0;
      for (int k = 0; k < MAXL; k++) lens[p][k] = int'($urandom_range(300, 1));
    end
    // Reference: every port is always backlogged, so the scheduler reduces
    // to classic DWRR over a fixed cyclic order of enabled ports.
    ptr = 0;
    while (expq.size() < NPKT) begin
      if (q[ptr] != 0) begin
        dm[ptr] += q[ptr];
        while (dm[ptr] > 0 && expq.size() < NPKT) begin
          expq.push_back(ptr);
          dm[ptr] -= lens[ptr][mpi[ptr]];
          mpi[ptr]++;
        end
      end
      ptr = (ptr + 1) % NP;
    end
    for (int p = 0; p < NP; p++) begin
      @(negedge clk); qwe = 1; qport = 2'(p); qdata = 16'(q[p]);
    end
    @(negedge clk); idle(); req = 4'b1111;

    npk = 0; cyc = 0; inpkt = 0; rem = 0; cur = 0;
    while (npk < NPKT && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      acc = 0; lst = 0; nbytes = '0;
      if (gv) begin
        if (!inpkt) begin
          cur   = int'(gidx);
          inpkt = 1;
          rem   = lens[cur][dpi[cur]];
          check($sformatf("rand_pkt%0d_port", npk), 32'(gidx), 32'(expq[npk]));
          check($sformatf("rand_pkt%0d_onehot", npk), 32'(grant), 32'(4'b0001 << gidx));
        end else begin
          check($sformatf("rand_pkt%0d_midpkt_idx", npk), 32'(gidx), 32'(cur));
        end
        if ($urandom_range(3, 0) != 0) begin
          acc    = 1;
          nbytes = (rem > 64) ? 7'd64 : 7'(rem);
          lst    = (rem <= 64);
          rem   -= int'(nbytes);
          if (lst) begin
            inpkt = 0;
            dpi[cur]++;
            npk++;
          end
        end
      end
    end
    if (npk < NPKT) check("rand_timeout_packets", 32'(npk), 32'(NPKT));
    @(negedge clk); idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
